// File: rtl/matrix_mult_seq.sv
// rtl/matrix_mult_seq.sv - sequential N x N unsigned matrix multiplier, one shared MAC per clock
//
// Computes C = A x B. The operands are captured on start, and then N^3 MAC cycles
// run with k innermost, then j, then i. Each finished element goes into an internal
// buffer, and the whole buffer is copied to C in a single step at completion.
//
// Build option: define MATMUL_SAT_EN to saturate each element to 2^W-1 instead of
// wrapping, and to add the sat output.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   operation request, sampled only when idle
//   A, B   in   N*N*W operands, element (i,j) at [(i*N+j)*W +: W]
//   C      out  N*N*W registered result, same packing
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when C is updated
//   sat    out  (MATMUL_SAT_EN only) any element of the last operation saturated

module matrix_mult_seq #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int ACC_W = 2*W + $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N*N*W-1:0] A,
    input  logic [N*N*W-1:0] B,
    output logic [N*N*W-1:0] C,
    output logic             busy,
    output logic             done
`ifdef MATMUL_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

    typedef enum logic {S_IDLE, S_MAC} state_t;

    state_t             r_state;
    logic [N*N*W-1:0]   r_a;
    logic [N*N*W-1:0]   r_b;
    logic [N*N*W-1:0]   r_buf;
    logic [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_j;
    logic [IDX_W-1:0]   r_k;

    logic [W-1:0]       w_a_elem;
    logic [W-1:0]       w_b_elem;
    logic [2*W-1:0]     w_prod;
    logic [ACC_W-1:0]   w_sum;
    logic [W-1:0]       w_res;
    logic [N*N*W-1:0]   w_buf_next;
    logic               w_k_last;
    logic               w_j_last;
    logic               w_i_last;

`ifdef MATMUL_SAT_EN
    logic               r_sat_any;
    logic               w_sat_elem;
`endif

    always_comb begin
        w_a_elem = r_a[(int'(r_i)*N + int'(r_k))*W +: W];
        w_b_elem = r_b[(int'(r_k)*N + int'(r_j))*W +: W];
        w_prod   = (2*W)'(w_a_elem) * (2*W)'(w_b_elem);
        w_sum    = r_acc + ACC_W'(w_prod);
        w_k_last = (r_k == LAST);
        w_j_last = (r_j == LAST);
        w_i_last = (r_i == LAST);
`ifdef MATMUL_SAT_EN
        // The full-width sum exceeds 2^W-1 exactly when any bit above W-1 is set.
        w_sat_elem = (w_sum[ACC_W-1:W] != '0);
        w_res      = w_sat_elem ? {W{1'b1}} : w_sum[W-1:0];
`else
        w_res      = w_sum[W-1:0];
`endif
        // The buffer already includes the element finishing this cycle, so the last
        // element of the matrix reaches C together with all the others.
        w_buf_next = r_buf;
        w_buf_next[(int'(r_i)*N + int'(r_j))*W +: W] = w_res;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_buf   <= '0;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            C       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef MATMUL_SAT_EN
            r_sat_any <= 1'b0;
            sat       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= S_MAC;
`ifdef MATMUL_SAT_EN
                        r_sat_any <= 1'b0;
                        sat       <= 1'b0;
`endif
                    end
                end
                S_MAC: begin
                    if (!w_k_last) begin
                        r_acc <= w_sum;
                        r_k   <= r_k + 1'b1;
                    end else begin
                        r_acc <= '0;
                        r_buf <= w_buf_next;
                        r_k   <= '0;
`ifdef MATMUL_SAT_EN
                        r_sat_any <= r_sat_any | w_sat_elem;
`endif
                        if (!w_j_last) begin
                            r_j <= r_j + 1'b1;
                        end else begin
                            r_j <= '0;
                            if (!w_i_last) begin
                                r_i <= r_i + 1'b1;
                            end else begin
                                r_i     <= '0;
                                C       <= w_buf_next;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= S_IDLE;
`ifdef MATMUL_SAT_EN
                                sat     <= r_sat_any | w_sat_elem;
`endif
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
- Parametrised N x N unsigned matrix multiplier; successor to the fixed 2x2 8-bit multiplier in the execute stage.
- Computes C = A x B with a single shared multiply-accumulate (MAC) unit, one MAC per clock.
- Accepts the same row-major packed operand buses as the 2x2 block, extended to any N and element width.
- Uses a start/busy/done handshake so the pipeline can stall on busy.

Parameters:
- N, 2, matrix dimension (N >= 2).
- W, 8, element width in bits for A, B and C.
- ACC_W, 2*W+$clog2(N), internal accumulator width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- A  in  N*N*W  operand A; element (i,j) at bits [(i*N+j)*W +: W].
- B  in  N*N*W  operand B; same packing as A.
- C  out  N*N*W  result; same packing; registered.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when C is updated.

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE and C=0, busy=0, done=0. Counters, accumulator and operand registers are cleared.
- Reset mid-operation aborts the operation: C keeps no partial result (it is 0 after reset) and no done pulse is issued.
- States: IDLE, MAC.
- IDLE, start=1 at edge E0:
  - Capture A and B into internal registers; the caller may change A and B afterwards.
  - Clear the accumulator; set i=j=k=0; busy<=1; go to MAC.
- MAC, edges E1..E(N^3), one per cycle:
  - acc <= acc + A[i][k]*B[k][j], computed at ACC_W bits with no internal overflow.
  - Loop order: k innermost, then j, then i.
  - When k==N-1: write the final sum for (i,j), reduced to W bits, into the internal result buffer; clear acc; advance j, then i.
  - At edge E(N^3) (i=j=k=N-1): load the full buffer into C in one step; done<=1; busy<=0; go to IDLE.
- C changes only at completion and never shows partial results. It holds its value until the next completion or reset.
- Latency: done is visible in the cycle after edge E(N^3), i.e. N^3 cycles after the start edge. With N=2 that is 8 cycles.
- done is high for exactly one cycle and low at every other time.
- start while busy=1 is ignored: no queueing, no error, operands not re-captured.
- start=1 in the done cycle is legal (state is IDLE) and is accepted. Back-to-back throughput is one result per N^3+1 cycles.
- start held high continuously restarts a new operation each time IDLE is reached.
- Width reduction (default): W-bit wrap, i.e. result = sum mod 2^W, matching the 2x2 block.
- All arithmetic is unsigned.

Optional Feature:
- Macro: MATMUL_SAT_EN.
- Defined: each result element saturates to 2^W-1 if the full ACC_W sum exceeds 2^W-1. Adds output sat (1 bit), registered with C: high if any element of the operation saturated; cleared at reset and at each start acceptance.
- Not defined: W-bit wrap, no sat port. Timing is identical in both builds.

Test Plan:
- Basic product, N=2, W=8: A=0x04030201 ([[1,2],[3,4]]), B=0x08070605 ([[5,6],[7,8]]), start pulse -> busy high for 8 cycles, done pulse in cycle 8, C=0x322B1613 ([[19,22],[43,50]]).
- Overflow, N=2: A=0x10101010, B=0x10101010 (each sum 512) -> C=0x00000000 without MATMUL_SAT_EN; C=0xFFFFFFFF and sat=1 with it.
- Operand stability and busy-ignore: start, then change A/B to 0xFFFFFFFF and pulse start at cycle 3 -> result still 0x322B1613, exactly one done pulse, done at cycle 8.
- Back-to-back: hold start=1 through the done cycle with new operands A=B=identity 0x01000001 -> second done 9 cycles after the first; C=0x01000001.
- Reset mid-op: assert rst_n=0 at cycle 4 for one edge -> C=0, busy=0, no done pulse. A new start afterwards completes normally.
- N=3, W=16 instance: A=identity, B=elements 1..9 row-major -> done after 27 cycles, C equals B.
